ascii_to_binary: RTL and testbench

ASCII_TO_BINARY -- requirements
Module: ascii_to_binary

---
 rtl/ascii_to_binary.sv | 159 +++++++++++++++
 tb/tb_ascii_to_binary.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ascii_to_binary.sv
// Converts four left-justified, space-padded ASCII bytes to an 8-bit value in a fixed 4-cycle scan.
// Define ASCII_SIGN_EN to accept a leading '-' and produce a two's complement result.
module ascii_to_binary (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifStart,
    input  logic [31:0] asciiNum,
    output logic [7:0]  binaryNum,
    output logic        ifNeg,
    output logic        ifError,
    output logic        ifDone,
    output logic        ifBusy
);
    localparam int unsigned AccW  = 10;
    localparam int unsigned WideW = 12;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state;
    logic [31:0]     word;
    logic [1:0]      idx;
    logic [AccW-1:0] acc;
    logic            ovf, err, seenSpace, seenDigit;
`ifdef ASCII_SIGN_EN
    logic            neg, negNext, isMinus;
`endif

    logic [7:0]       curByte;
    logic             isDigit, isSpace;
    logic [WideW-1:0] accProd, limit;
    logic [AccW-1:0]  accNext;
    logic             ovfNext, errNext, seenSpaceNext, seenDigitNext, failNext;
    logic [7:0]       magnitude;

    // Effect of the byte currently at the head of the latched word
    always_comb begin
        curByte       = word[31:24];
        isDigit       = (curByte >= 8'h30) && (curByte <= 8'h39);
        isSpace       = (curByte == 8'h20);
        accProd       = (WideW'(acc) * WideW'(10)) + WideW'(curByte[3:0]);
        accNext       = acc;
        ovfNext       = ovf;
        errNext       = err;
        seenSpaceNext = seenSpace;
        seenDigitNext = seenDigit;
`ifdef ASCII_SIGN_EN
        isMinus       = (curByte == 8'h2D);
        negNext       = neg;
        limit         = neg ? WideW'(128) : WideW'(255);
`else
        limit         = WideW'(255);
`endif
        if (isDigit) begin
            seenDigitNext = 1'b1;
            if (seenSpace) begin
                errNext = 1'b1;
            end else if (!ovf) begin
                if (accProd > limit) begin
                    ovfNext = 1'b1;
                end else begin
                    accNext = AccW'(accProd);
                end
            end
        end else if (isSpace) begin
            seenSpaceNext = 1'b1;
`ifdef ASCII_SIGN_EN
        end else if (isMinus && (idx == 2'd0)) begin
            negNext = 1'b1;
`endif
        end else begin
            errNext = 1'b1;
        end
        failNext  = errNext | ovfNext | ~seenDigitNext;
        magnitude = accNext[7:0];
    end

`ifndef ASCII_SIGN_EN
    assign ifNeg = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word      <= '0;
            idx       <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            seenSpace <= 1'b0;
            seenDigit <= 1'b0;
            binaryNum <= '0;
            ifError   <= 1'b0;
            ifDone    <= 1'b0;
            ifBusy    <= 1'b0;
`ifdef ASCII_SIGN_EN
            neg       <= 1'b0;
            ifNeg     <= 1'b0;
`endif
        end else begin
            ifDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (ifStart) begin
                        word      <= asciiNum;
                        idx       <= '0;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        err       <= 1'b0;
                        seenSpace <= 1'b0;
                        seenDigit <= 1'b0;
`ifdef ASCII_SIGN_EN
                        neg       <= 1'b0;
`endif
                        ifBusy    <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    word      <= {word[23:0], 8'h00};
                    idx       <= idx + 2'd1;
                    acc       <= accNext;
                    ovf       <= ovfNext;
                    err       <= errNext;
                    seenSpace <= seenSpaceNext;
                    seenDigit <= seenDigitNext;
`ifdef ASCII_SIGN_EN
                    neg       <= negNext;
`endif
                    if (idx == 2'd3) begin
                        state   <= IDLE;
                        ifBusy  <= 1'b0;
                        ifDone  <= 1'b1;
                        ifError <= failNext;
                        if (failNext) begin
                            binaryNum <= '0;
`ifdef ASCII_SIGN_EN
                            ifNeg     <= 1'b0;
`endif
                        end else begin
`ifdef ASCII_SIGN_EN
                            // "-0" collapses to a plain zero
                            if (negNext && (magnitude != 8'd0)) begin
                                binaryNum <= (~magnitude) + 8'd1;
                                ifNeg     <= 1'b1;
                            end else begin
                                binaryNum <= magnitude;
                                ifNeg     <= 1'b0;
                            end
`else
                            binaryNum <= magnitude;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascii_to_binary.sv
// Scoreboard bench for ascii_to_binary: random and directed strings against a string-parsing reference model.
module tb_ascii_to_binary;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifStart;
    logic [31:0] asciiNum;
    logic [7:0]  binaryNum;
    logic        ifNeg, ifError, ifDone, ifBusy;

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;
    int doneCount = 0;
    int doneCycles[$];
    logic [9:0] expQ[$];

    ascii_to_binary dut (
        .clk(clk), .rst(rst), .ifStart(ifStart), .asciiNum(asciiNum),
        .binaryNum(binaryNum), .ifNeg(ifNeg), .ifError(ifError),
        .ifDone(ifDone), .ifBusy(ifBusy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {error, negative, value} from the text read as a decimal number
    function automatic logic [9:0] refModel(input logic [31:0] w);
        logic [7:0] c[4];
        int first, pos, val, lim;
        bit neg, bad;
        for (int i = 0; i < 4; i++) c[i] = w[31-8*i -: 8];
        first = 0; neg = 0; bad = 0; val = 0;
`ifdef ASCII_SIGN_EN
        if (c[0] == 8'h2D) begin neg = 1; first = 1; end
`endif
        pos = first;
        while (pos < 4 && c[pos] >= 8'h30 && c[pos] <= 8'h39) begin
            val = val * 10 + int'(c[pos] - 8'h30);
            pos++;
        end
        if (pos == first) bad = 1;
        for (int i = pos; i < 4; i++) if (c[i] != 8'h20) bad = 1;
        lim = neg ? 128 : 255;
        if (val > lim) bad = 1;
        if (bad) return {2'b10, 8'h00};
        if (neg && val != 0) return {2'b01, 8'(256 - val)};
        return {2'b00, 8'(val)};
    endfunction

    function automatic logic [31:0] mkNum(input int v, input bit neg, input int zeros);
        logic [7:0] ch[$];
        int digs[$];
        logic [31:0] w;
        int t;
        t = v;
        do begin digs.push_front(t % 10); t = t / 10; end while (t > 0);
        if (neg) ch.push_back(8'h2D);
        for (int i = 0; i < zeros; i++) ch.push_back(8'h30);
        foreach (digs[i]) ch.push_back(8'(8'h30 + digs[i]));
        while (ch.size() < 4) ch.push_back(8'h20);
        for (int i = 0; i < 4; i++) w[31-8*i -: 8] = ch[i];
        return w;
    endfunction

    function automatic logic [31:0] mkRandom();
        logic [31:0] w;
        int r;
        for (int i = 0; i < 4; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      w[31-8*i -: 8] = 8'(8'h30 + $urandom_range(0, 9));
            else if (r < 80) w[31-8*i -: 8] = 8'h20;
            else if (r < 87) w[31-8*i -: 8] = 8'h2D;
            else             w[31-8*i -: 8] = 8'($urandom);
        end
        return w;
    endfunction

    task automatic waitIdle();
        int t;
        t = 0;
        @(negedge clk);
        while (ifBusy && t < 20) begin @(negedge clk); t++; end
        if (ifBusy) check("idle_timeout", 1, 0);
    endtask

    // One start pulse; asciiNum is scrambled right after acceptance
    task automatic convert(input logic [31:0] w);
        int busy;
        waitIdle();
        asciiNum = w;
        ifStart  = 1'b1;
        expQ.push_back(refModel(w));
        @(posedge clk);
        #1;
        ifStart  = 1'b0;
        asciiNum = $urandom;
        busy = 0;
        @(negedge clk);
        while (ifBusy && busy < 10) begin busy++; @(negedge clk); end
        check("busy_cycles", busy, 4);
    endtask

    // Monitor: pops expectations whenever a completion is presented
    always @(negedge clk) begin
        if (!rst && ifDone) begin
            doneCount++;
            doneCycles.push_back(cyc);
            if (expQ.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [9:0] e;
                e = expQ.pop_front();
                check("result{err,neg,bin}", int'({ifError, ifNeg, binaryNum}), int'(e));
            end
        end
    end

    logic [31:0] directed[14] = '{
        32'h32353520, 32'h37202020, 32'h32353620, 32'h31203220, 32'h20202020,
        32'h31612020, 32'h30323535, 32'h30303020, 32'h2D352020, 32'h2D313238,
        32'h2D313239, 32'h2D302020, 32'h32353532, 32'h39393939
    };

    initial begin
        int snap;
        rst = 1'b1; ifStart = 1'b0; asciiNum = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({binaryNum, ifNeg, ifError, ifDone, ifBusy}), 0);
        rst = 1'b0;

        foreach (directed[i]) convert(directed[i]);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 2))
                0: convert(mkNum(int'($urandom_range(0, 300)), ($urandom_range(0, 3) == 0),
                                 int'($urandom_range(0, 1))));
                1: convert(mkRandom());
                default: convert($urandom);
            endcase
        end

        // Held start: back-to-back conversions every 5 cycles, mid-scan starts ignored
        waitIdle();
        waitIdle();
        doneCycles.delete();
        asciiNum = 32'h34322020;
        ifStart  = 1'b1;
        for (int k = 0; k < 26; k++) begin
            if (!ifBusy) expQ.push_back(refModel(32'h34322020));
            @(posedge clk);
            @(negedge clk);
        end
        ifStart = 1'b0;
        waitIdle();
        repeat (2) @(negedge clk);
        check("held_done_count_ge4", int'(doneCycles.size() >= 4), 1);
        for (int k = 1; k < doneCycles.size(); k++)
            check("done_interval", doneCycles[k] - doneCycles[k-1], 5);

        // Reset at E2 aborts the scan silently
        convert(32'h32353520);
        waitIdle();
        asciiNum = 32'h31323320;
        ifStart  = 1'b1;
        @(posedge clk);
        #1;
        ifStart = 1'b0;
        @(posedge clk);
        @(negedge clk);
        snap = doneCount;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs", int'({binaryNum, ifNeg, ifError, ifDone, ifBusy}), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_done", doneCount, snap);
        convert(32'h31323320);
        repeat (3) @(negedge clk);
        check("after_abort_value", int'(binaryNum), 8'h7B);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
